de10_io_counter: RTL

DE10_IO_COUNTER -- requirements
Module: de10_io_counter

---
 rtl/de10_io_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/de10_io_counter.sv
// DE10 I/O counter: debounced pushbuttons inc/dec/load/clear a hex counter that can also auto-tick.
// Latency: count moves one edge after a press pulse, LEDR/SS one edge later; no backpressure, inputs free-running.
module de10_io_counter #(
  parameter int SW_W            = 10,
  parameter int PB_W            = 4,
  parameter int LED_W           = 10,
  parameter int SEGMENT_W       = 8,
  parameter int DISPLAY_W       = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [PB_W-1:0]                     PB,
  input  logic [SW_W-1:0]                     SW,
  output logic [LED_W-1:0]                    LEDR,
  output logic [DISPLAY_W-1:0][SEGMENT_W-1:0] SS
);

  localparam int CNT_W = 4 * DISPLAY_W;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W  = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  logic [PB_W-1:0]            pb_s1, pb_s2;
  logic [SW_W-1:0]            sw_s1, sw_s2;
  logic [1:0]                 sync_fill;
  logic [3:0]                 pb_acc, pb_acc_d, armed, press;
  logic [3:0][DB_W-1:0]       db_cnt;
  logic [TK_W-1:0]            tick;
  logic                       auto_on, any_ev, tick_fire;
  logic [CNT_W-1:0]           count, count_next;
  logic                       unused_pb;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    hex7 = 7'h7F;
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // Buttons above PB[3] are synchronized but carry no function.
  assign unused_pb = ^pb_s2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pb_s1     <= '1;
      pb_s2     <= '1;
      sw_s1     <= '0;
      sw_s2     <= '0;
      sync_fill <= '0;
    end else begin
      pb_s1     <= PB;
      pb_s2     <= pb_s1;
      sw_s1     <= SW;
      sw_s2     <= sw_s1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // A button arms only once it has been seen released after reset, so a
  // button held through reset release never produces a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pb_acc   <= '1;
      pb_acc_d <= '1;
      armed    <= '0;
      db_cnt   <= '0;
    end else begin
      pb_acc_d <= pb_acc;
      for (int i = 0; i < 4; i++) begin
        if (sync_fill[1] && pb_s2[i]) armed[i] <= 1'b1;
        if (pb_s2[i] == pb_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          pb_acc[i] <= pb_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = pb_acc_d & ~pb_acc & armed;
  assign any_ev    = |press;
  assign auto_on   = sw_s2[SW_W-1];
  assign tick_fire = auto_on && !any_ev && (tick == TK_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   tick <= '0;
    else if (!auto_on || any_ev || tick_fire)  tick <= '0;
    else                                       tick <= tick + 1'b1;
  end

  always_comb begin
    count_next = count;
    if (press[3])               count_next = '0;
    else if (press[2])          count_next = CNT_W'(sw_s2[SW_W-2:0]);
    else if (press[0] ^ press[1])
      count_next = press[0] ? count + 1'b1 : count - 1'b1;
    else if (tick_fire)         count_next = count + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count <= '0;
    else     count <= count_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEDR <= '0;
      for (int d = 0; d < DISPLAY_W; d++) SS[d] <= SEGMENT_W'(8'hC0);
    end else begin
      LEDR <= LED_W'(count);
      for (int d = 0; d < DISPLAY_W; d++)
        SS[d] <= SEGMENT_W'({((d == 0) ? ~auto_on : 1'b1), hex7(count[4*d +: 4])});
    end
  end

endmodule
